// File: rtl/cnu_min_sched.sv
`default_nettype none
// ============================================================================
// Module : cnu_min_sched
// Brief  : Round-robin scheduler sharing one merge_ppl min/min2 finder among
//          N_REQ requesters, with credit-throttled issue into a result FIFO.
// Rev    : 1.0  initial release
// ============================================================================
module cnu_min_sched #(
  parameter int N_REQ  = 4,
  parameter int SRC_W  = 2,
  parameter int D      = 5,
  parameter int data_w = 8,
  parameter int idx_w  = 8,
  parameter int TAG_W  = 6,
  parameter int LAT    = 2,
  parameter int FIFO_D = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ*data_w*D-1:0]   req_data,
  input  logic [N_REQ*TAG_W-1:0]      req_tag,
  output logic [data_w*D-1:0]         pp_in,
  input  logic [data_w-1:0]           pp_min,
  input  logic [data_w-1:0]           pp_min2,
  input  logic [idx_w-1:0]            pp_min_idx,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [data_w-1:0]           out_min,
  output logic [data_w-1:0]           out_min2,
  output logic [idx_w-1:0]            out_min_idx,
  output logic [SRC_W-1:0]            out_src,
  output logic [TAG_W-1:0]            out_tag,
  output logic                        busy
);

  localparam int ROW_W = data_w * D;
  localparam int ENT_W = 2 * data_w + idx_w + SRC_W + TAG_W;
  localparam int CNT_W = $clog2(FIFO_D + 1);
  localparam int AW    = $clog2(FIFO_D);
  localparam int INF_W = $clog2(LAT + 2);
  localparam int SUM_W = ((CNT_W > INF_W) ? CNT_W : INF_W) + 1;
  localparam int NT    = LAT + 1;

  logic [SRC_W-1:0] r_ptr;
  logic [ROW_W-1:0] r_pp_in;
  logic [NT-1:0]    r_trk_v;
  logic [SRC_W-1:0] r_trk_src [NT];
  logic [TAG_W-1:0] r_trk_tag [NT];
  logic [ENT_W-1:0] r_mem [FIFO_D];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CNT_W-1:0] r_count;

  logic [INF_W-1:0] w_inflight;
  logic [SUM_W-1:0] w_sum;
  logic             w_can_issue;
  logic             w_found;
  logic             w_fire;
  logic             w_push;
  logic             w_pop;
  int               w_best;
  logic [SRC_W-1:0] w_gnt_id;
  logic [SRC_W-1:0] w_ptr_nxt;
  logic [N_REQ-1:0] w_grant;
  logic [ROW_W-1:0] w_row;
  logic [TAG_W-1:0] w_tag;

  // Credits cover every row already committed: buffered plus in the pipeline.
  always_comb begin
    w_inflight = '0;
    for (int k = 0; k < NT; k++) w_inflight = w_inflight + INF_W'(r_trk_v[k]);
  end
  assign w_sum       = SUM_W'(r_count) + SUM_W'(w_inflight);
  assign w_can_issue = (w_sum < SUM_W'(FIFO_D));

  // Pick the valid requester with the smallest distance from r_ptr.
  always_comb begin
    w_found  = 1'b0;
    w_gnt_id = '0;
    w_best   = N_REQ;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_valid[i] && (((i - int'(r_ptr) + N_REQ) % N_REQ) < w_best)) begin
        w_best   = (i - int'(r_ptr) + N_REQ) % N_REQ;
        w_gnt_id = SRC_W'(i);
        w_found  = 1'b1;
      end
    end
  end

  always_comb begin
    w_grant = '0;
    w_row   = '0;
    w_tag   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt_id == SRC_W'(i)) begin
        w_row = req_data[i*ROW_W +: ROW_W];
        w_tag = req_tag[i*TAG_W +: TAG_W];
        w_grant[i] = w_found & w_can_issue & ~rst;
      end
    end
  end

  assign req_ready = w_grant;
  assign w_fire    = |w_grant;
  assign w_ptr_nxt = (int'(w_gnt_id) == N_REQ - 1) ? '0 : w_gnt_id + 1'b1;
  assign w_push    = r_trk_v[LAT];
  assign w_pop     = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= '0;
      r_pp_in <= '0;
      r_trk_v <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      r_trk_v <= {r_trk_v[NT-2:0], w_fire};
      if (w_fire) begin
        r_ptr   <= w_ptr_nxt;
        r_pp_in <= w_row;
      end
      if (w_push) r_wr <= (r_wr == AW'(FIFO_D - 1)) ? '0 : r_wr + 1'b1;
      if (w_pop)  r_rd <= (r_rd == AW'(FIFO_D - 1)) ? '0 : r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload needs no reset: it is qualified by r_trk_v and the FIFO pointers.
  always_ff @(posedge clk) begin
    r_trk_src[0] <= w_gnt_id;
    r_trk_tag[0] <= w_tag;
    for (int k = 1; k < NT; k++) begin
      r_trk_src[k] <= r_trk_src[k-1];
      r_trk_tag[k] <= r_trk_tag[k-1];
    end
    if (w_push) r_mem[r_wr] <= {pp_min, pp_min2, pp_min_idx, r_trk_src[LAT], r_trk_tag[LAT]};
  end

  assign pp_in     = r_pp_in;
  assign out_valid = (r_count != '0);
  assign {out_min, out_min2, out_min_idx, out_src, out_tag} = r_mem[r_rd];
  assign busy      = (w_inflight != '0) | (r_count != '0);

endmodule
`default_nettype wire
